shared_mem_responder: RTL and testbench

- Memory-side responder on the shared accelerator memory bus (mem_w, mem_sel, address_bus, data_bus) used by the pooling and convolution engines.
- Stores 2**ADDR_WIDTH words of DATABUS_WIDTH bits.
  - Reads are served combinationally in the same cycle.
  - Writes are committed on the clock edge.
- Also provides a sideband host port for bench/controller preload and readback, and a sequenced zero-fill (clear) engine.

---
 rtl/shared_mem_responder_pkg.sv | 33 +++
 rtl/shared_mem_responder_if.sv | 39 +++
 rtl/shared_mem_responder_array.sv | 34 +++
 rtl/shared_mem_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_shared_mem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the accelerator memory bus: default widths used by
// the pooling/convolution initiators and by the responder, bus direction
// encodings, the responder FSM state type and a saturating counter helper.
// ---------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH    = 8;
  localparam int DEF_DATABUS_WIDTH = 32;

  // Value of mem_w for each bus direction.
  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOST  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shared_mem_responder_if.sv
// ---------------------------------------------------------------------------
// shared_mem_responder_if
// Control signals of the shared memory bus plus the sideband host port.
//   mem_w, mem_sel, address_bus : bus initiator direction, strobe, address
//   host_req/we/addr/wdata      : host access request (level, held to ack)
//   host_rdata, host_ack        : host read data and completion pulse
// The bidirectional data_bus is a plain inout on the responder so that it
// can be resolved as an ordinary tri-state net.
// Modports: master = initiator/host side, slave = responder side.
// ---------------------------------------------------------------------------
interface shared_mem_responder_if #(
  parameter int ADDR_WIDTH    = mem_bus_pkg::DEF_ADDR_WIDTH,
  parameter int DATABUS_WIDTH = mem_bus_pkg::DEF_DATABUS_WIDTH
);

  logic                     mem_w;
  logic                     mem_sel;
  logic [ADDR_WIDTH-1:0]    address_bus;

  logic                     host_req;
  logic                     host_we;
  logic [ADDR_WIDTH-1:0]    host_addr;
  logic [DATABUS_WIDTH-1:0] host_wdata;
  logic [DATABUS_WIDTH-1:0] host_rdata;
  logic                     host_ack;

  modport master (
    output mem_w, mem_sel, address_bus,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack
  );

  modport slave (
    input  mem_w, mem_sel, address_bus,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack
  );

endinterface

// File: rtl/shared_mem_responder_array.sv
// ---------------------------------------------------------------------------
// mem_array_1w1r
// Storage array with one synchronous write port and one combinational read
// port. Contents are never reset.
//   clk          : clock
//   we/waddr/wdata : write committed on posedge clk when we = 1
//   raddr/rdata  : asynchronous read
// ---------------------------------------------------------------------------
module mem_array_1w1r #(
  parameter int ADDR_WIDTH    = mem_bus_pkg::DEF_ADDR_WIDTH,
  parameter int DATABUS_WIDTH = mem_bus_pkg::DEF_DATABUS_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_WIDTH-1:0]    waddr,
  input  logic [DATABUS_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]    raddr,
  output logic [DATABUS_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATABUS_WIDTH-1:0] mem_r [0:DEPTH-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/shared_mem_responder.sv
// ---------------------------------------------------------------------------
// shared_mem_responder
// Memory-side responder for the shared accelerator memory bus.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : mem_w/mem_sel/address_bus from the initiator, host port
//   data_bus      : driven here only for bus reads, Z otherwise
//   clear_start   : pulse, zero-fills the whole array (accepted in IDLE)
//   busy          : high while the zero-fill runs
//   clear_done    : one-cycle pulse when the fill completes
//   bus_err       : sticky, set by any bus access during the fill
// Optional build macro SHARED_MEM_ACCESS_CNT_EN adds rd_count/wr_count,
// saturating counts of bus read and write cycles.
//
// Bus reads are zero-latency (combinational); bus writes commit on the edge.
// The bus always has priority over the host port.
// ---------------------------------------------------------------------------
module shared_mem_responder #(
  parameter int ADDR_WIDTH    = mem_bus_pkg::DEF_ADDR_WIDTH,
  parameter int DATABUS_WIDTH = mem_bus_pkg::DEF_DATABUS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  shared_mem_responder_if.slave    bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  input  logic                     clear_start,
  output logic                     busy,
  output logic                     clear_done,
  output logic                     bus_err
`ifdef SHARED_MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
`endif
);

  import mem_bus_pkg::*;

  localparam logic [ADDR_WIDTH-1:0]    ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [DATABUS_WIDTH-1:0] DATA_ZERO = {DATABUS_WIDTH{1'b0}};
  localparam logic [DATABUS_WIDTH-1:0] DATA_Z    = {DATABUS_WIDTH{1'bz}};

  state_t                   state_r;
  state_t                   state_s;
  logic [ADDR_WIDTH-1:0]    clr_cnt_r;
  logic                     busy_r;
  logic                     clear_done_r;
  logic                     host_ack_r;
  logic [DATABUS_WIDTH-1:0] host_rdata_r;
  logic                     bus_err_r;

  logic                     bus_rd_s;
  logic                     bus_wr_s;
  logic                     grant_s;
  logic                     host_stall_s;
  logic                     clr_last_s;

  logic                     we_s;
  logic [ADDR_WIDTH-1:0]    waddr_s;
  logic [DATABUS_WIDTH-1:0] wdata_s;
  logic [ADDR_WIDTH-1:0]    raddr_s;
  logic [DATABUS_WIDTH-1:0] rdata_s;

  assign bus_rd_s   = bus.mem_sel && (bus.mem_w == MEM_RD);
  assign bus_wr_s   = bus.mem_sel && (bus.mem_w == MEM_WR);
  assign clr_last_s = (clr_cnt_r == ADDR_LAST);

  // The host is granted only when the bus is quiet, so the single read port
  // is free in the grant cycle; host reads are captured there. Nothing can
  // write the array in that cycle, so the captured word equals what the
  // array holds during the following HOST cycle.
  assign grant_s = (state_r == IDLE) && !clear_start && bus.host_req && !bus.mem_sel;

  // A bus write in the HOST cycle owns the write port. If it targets a
  // different word the host write has not landed yet, so HOST is held for
  // another cycle; to the same word the bus value simply wins.
  assign host_stall_s = (state_r == HOST) && bus.host_we && bus_wr_s &&
                        (bus.address_bus != bus.host_addr);

  assign raddr_s = grant_s ? bus.host_addr : bus.address_bus;

  // During the fill the array is in an undefined mixed state, so bus reads
  // see zero rather than stale contents.
  assign data_bus = bus_rd_s ? ((state_r == CLEAR) ? DATA_ZERO : rdata_s) : DATA_Z;

  mem_array_1w1r #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATABUS_WIDTH (DATABUS_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear_start) begin
          state_s = CLEAR;
        end else if (bus.host_req && !bus.mem_sel) begin
          state_s = HOST;
        end else begin
          state_s = IDLE;
        end
      end
      HOST: begin
        if (host_stall_s) begin
          state_s = HOST;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (clr_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Write-port mux: fill, then bus, then host. No write commits while rst
  // is asserted, so a reset in the middle of a fill leaves the current
  // word untouched.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = bus.address_bus;
    wdata_s = data_bus;
    if (rst) begin
      we_s = 1'b0;
    end else if (state_r == CLEAR) begin
      we_s    = 1'b1;
      waddr_s = clr_cnt_r;
      wdata_s = DATA_ZERO;
    end else if (bus_wr_s) begin
      we_s = 1'b1;
    end else if ((state_r == HOST) && bus.host_we) begin
      we_s    = 1'b1;
      waddr_s = bus.host_addr;
      wdata_s = bus.host_wdata;
    end else begin
      we_s = 1'b0;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      clr_cnt_r    <= ADDR_ZERO;
      busy_r       <= 1'b0;
      clear_done_r <= 1'b0;
      host_ack_r   <= 1'b0;
      host_rdata_r <= DATA_ZERO;
      bus_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      clear_done_r <= 1'b0;
      host_ack_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clear_start) begin
            clr_cnt_r <= ADDR_ZERO;
            busy_r    <= 1'b1;
            bus_err_r <= 1'b0;
          end else if (grant_s && !bus.host_we) begin
            host_rdata_r <= rdata_s;
          end
        end
        HOST: begin
          if (!host_stall_s) begin
            host_ack_r <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt_r <= clr_cnt_r + ADDR_ONE;
          if (bus.mem_sel) begin
            bus_err_r <= 1'b1;
          end
          if (clr_last_s) begin
            busy_r       <= 1'b0;
            clear_done_r <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHARED_MEM_ACCESS_CNT_EN
  logic [31:0] rd_count_r;
  logic [31:0] wr_count_r;

  // Saturating bus access counters; cleared together with the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_r <= 32'd0;
      wr_count_r <= 32'd0;
    end else if ((state_r == IDLE) && clear_start) begin
      rd_count_r <= 32'd0;
      wr_count_r <= 32'd0;
    end else begin
      if (bus_rd_s) begin
        rd_count_r <= sat_inc32(rd_count_r);
      end
      if (bus_wr_s) begin
        wr_count_r <= sat_inc32(wr_count_r);
      end
    end
  end

  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;
`endif

  assign busy           = busy_r;
  assign clear_done     = clear_done_r;
  assign bus_err        = bus_err_r;
  assign bus.host_ack   = host_ack_r;
  assign bus.host_rdata = host_rdata_r;

endmodule

// File: tb/tb_shared_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_shared_mem_responder
// Directed and randomized stimulus against a word-array reference model.
// ---------------------------------------------------------------------------
module tb_shared_mem_responder;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst;
  logic          clear_start;
  logic          busy;
  logic          clear_done;
  logic          bus_err;
  logic          tb_drv;
  logic [DW-1:0] tb_data;
  wire  [DW-1:0] data_bus;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [0:DEPTH-1];

`ifdef SHARED_MEM_ACCESS_CNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  shared_mem_responder_if #(.ADDR_WIDTH(AW), .DATABUS_WIDTH(DW)) bif ();

  assign data_bus = tb_drv ? tb_data : {DW{1'bz}};

  shared_mem_responder #(.ADDR_WIDTH(AW), .DATABUS_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .data_bus    (data_bus),
    .clear_start (clear_start),
    .busy        (busy),
    .clear_done  (clear_done),
    .bus_err     (bus_err)
`ifdef SHARED_MEM_ACCESS_CNT_EN
    ,
    .rd_count    (rd_count),
    .wr_count    (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bif.mem_sel = 1'b0;
    bif.mem_w   = 1'b0;
    tb_drv      = 1'b0;
  endtask

  // One host access; lat = number of edges until host_ack seen, -1 if none.
  task automatic host_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             output logic [DW-1:0] rdata, output int lat);
    bif.host_req   = 1'b1;
    bif.host_we    = we;
    bif.host_addr  = addr;
    bif.host_wdata = wdata;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bif.host_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    rdata        = bif.host_rdata;
    bif.host_req = 1'b0;
    bif.host_we  = 1'b0;
  endtask

  task automatic host_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [DW-1:0] rd;
    int lat;
    host_access(1'b1, addr, data, rd, lat);
    check("host_wr_latency", 64'(lat), 64'd2);
    model_mem[addr] = data;
  endtask

  task automatic host_rd(input logic [AW-1:0] addr, input string tag);
    logic [DW-1:0] rd;
    int lat;
    host_access(1'b0, addr, {DW{1'b0}}, rd, lat);
    check("host_rd_latency", 64'(lat), 64'd2);
    check(tag, 64'(rd), 64'(model_mem[addr]));
  endtask

  task automatic bus_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bif.mem_sel     = 1'b1;
    bif.mem_w       = 1'b1;
    bif.address_bus = addr;
    tb_drv          = 1'b1;
    tb_data         = data;
    tick();
    bus_idle();
  endtask

  // Bus read check within the current cycle; leaves mem_sel asserted.
  task automatic bus_rd_chk(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
    bif.mem_sel     = 1'b1;
    bif.mem_w       = 1'b0;
    bif.address_bus = addr;
    #1;
    check(tag, 64'(data_bus), 64'(exp));
    tick();
  endtask

  task automatic fill_all(input logic [DW-1:0] data);
    for (int i = 0; i < DEPTH; i++) begin
      bif.mem_sel     = 1'b1;
      bif.mem_w       = 1'b1;
      bif.address_bus = AW'(i);
      tb_drv          = 1'b1;
      tb_data         = data;
      tick();
      model_mem[i] = data;
    end
    bus_idle();
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
    int lat;
    int n_busy;
    int n_done;
    int n_ack;

    rst             = 1'b1;
    clear_start     = 1'b0;
    tb_drv          = 1'b0;
    tb_data         = {DW{1'b0}};
    bif.mem_sel     = 1'b0;
    bif.mem_w       = 1'b0;
    bif.address_bus = {AW{1'b0}};
    bif.host_req    = 1'b0;
    bif.host_we     = 1'b0;
    bif.host_addr   = {AW{1'b0}};
    bif.host_wdata  = {DW{1'b0}};
    for (int i = 0; i < DEPTH; i++) model_mem[i] = {DW{1'b0}};

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_clear_done", 64'(clear_done), 64'd0);
    check("rst_host_ack", 64'(bif.host_ack), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_host_rdata", 64'(bif.host_rdata), 64'd0);

    // Host preload of 0..15, then a zero-latency streamed bus read.
    for (int i = 0; i < 16; i++) host_wr(AW'(i), DW'(32'h11 + i));
    for (int i = 0; i < 16; i++) bus_rd_chk(AW'(i), DW'(32'h11 + i), "stream_rd");
    bus_idle();
    tick();

    // Bus write of 0xAB to 0x20; bench value must be the only driver.
    bif.mem_sel     = 1'b1;
    bif.mem_w       = 1'b1;
    bif.address_bus = 8'h20;
    tb_drv          = 1'b1;
    tb_data         = 32'hAB;
    #1;
    check("bus_wr_data_bus", 64'(data_bus), 64'h0000_00AB);
    tick();
    bus_idle();
    model_mem[8'h20] = 32'hAB;
    host_rd(8'h20, "host_rd_0x20");

    // Host request held off while the bus is busy for 5 cycles.
    bif.mem_sel     = 1'b1;
    bif.mem_w       = 1'b0;
    bif.address_bus = 8'd3;
    bif.host_req    = 1'b1;
    bif.host_we     = 1'b0;
    bif.host_addr   = 8'd7;
    n_ack = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("held_bus_rd", 64'(data_bus), 64'(model_mem[3]));
      tick();
      if (bif.host_ack === 1'b1) n_ack++;
    end
    check("held_no_ack", 64'(n_ack), 64'd0);
    bus_idle();
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (bif.host_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    rd = bif.host_rdata;
    bif.host_req = 1'b0;
    check("held_ack_latency", 64'(lat), 64'd2);
    check("held_rdata", 64'(rd), 64'(model_mem[7]));

    // Randomized writes via bus or host, read back via bus or host.
    for (int k = 0; k < 24; k++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        bus_wr(a, d);
        model_mem[a] = d;
      end else begin
        host_wr(a, d);
      end
      if ($urandom_range(0, 1) == 0) begin
        bus_rd_chk(a, model_mem[a], "rand_bus_rd");
        bus_idle();
      end else begin
        host_rd(a, "rand_host_rd");
      end
    end

    // Full clear with a dropped bus write, a zero bus read and an ignored restart.
    fill_all(32'hFF);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("clr_busy_start", 64'(busy), 64'd1);
    n_busy = 1;
    n_done = 0;
    for (int c = 0; c < 300; c++) begin
      if (c == 10) begin
        bif.mem_sel     = 1'b1;
        bif.mem_w       = 1'b1;
        bif.address_bus = 8'd3;
        tb_drv          = 1'b1;
        tb_data         = 32'h55;
      end
      if (c == 20) begin
        bif.mem_sel     = 1'b1;
        bif.mem_w       = 1'b0;
        bif.address_bus = 8'd200;
        #1;
        check("clr_bus_rd_zero", 64'(data_bus), 64'd0);
      end
      if (c == 30) clear_start = 1'b1;
      tick();
      bus_idle();
      clear_start = 1'b0;
      if (busy === 1'b1) n_busy++;
      if (clear_done === 1'b1) n_done++;
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = {DW{1'b0}};
    check("clr_busy_cycles", 64'(n_busy), 64'd256);
    check("clr_done_pulses", 64'(n_done), 64'd1);
    check("clr_bus_err", 64'(bus_err), 64'd1);
    for (int i = 0; i < DEPTH; i++) bus_rd_chk(AW'(i), model_mem[i], "clr_readback");
    bus_idle();
    tick();

    // Reset while the clear counter is at 100.
    fill_all(32'hFF);
    check("bus_err_sticky", 64'(bus_err), 64'd1);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("clr2_bus_err_cleared", 64'(bus_err), 64'd0);
    check("clr2_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 100; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    n_done = (clear_done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (clear_done === 1'b1) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    for (int i = 0; i < 100; i++) model_mem[i] = {DW{1'b0}};
    for (int i = 0; i < DEPTH; i++) bus_rd_chk(AW'(i), model_mem[i], "abort_readback");
    bus_idle();
    tick();

`ifdef SHARED_MEM_ACCESS_CNT_EN
    // Access counters: 16 reads + 4 writes, then zeroed by clear_start.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_rd_reset", 64'(rd_count), 64'd0);
    for (int i = 0; i < 16; i++) bus_rd_chk(AW'(i), model_mem[i], "cnt_bus_rd");
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      bus_wr(AW'(i), DW'(i));
      model_mem[i] = DW'(i);
    end
    tick();
    check("cnt_rd_16", 64'(rd_count), 64'd16);
    check("cnt_wr_4", 64'(wr_count), 64'd4);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("cnt_rd_cleared", 64'(rd_count), 64'd0);
    check("cnt_wr_cleared", 64'(wr_count), 64'd0);
    for (int c = 0; c < 300; c++) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
